// File: rtl/string_hw_feeder.sv
// rtl/string_hw_feeder.sv - sequences SRC_A/SRC_B words into a string accelerator and writes its result to DST
// Optional feature macro: STRING_HW_FEEDER_IRQ_EN (level completion interrupt).
module string_hw_feeder #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  csr_address,
    input  logic        csr_write,
    input  logic        csr_read,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    output logic [2:0]  acc_address,
    output logic        acc_chipselect,
    output logic        acc_read,
    output logic        acc_write,
    output logic [31:0] acc_writedata,
    input  logic [31:0] acc_readdata,
    output logic        irq
);

    typedef enum logic [3:0] {
        IDLE, RD_A, WR_A, RD_B, WR_B, GO, POLL_RD, POLL_CHK,
        RES_RD, RES_CAP, WR_DST, DONE, ERR
    } state_t;

    state_t      state, next_state;
    logic [31:0] src_a, src_b, dst, result, word;
    logic [2:0]  index, length;
    logic [31:0] poll_cnt;
    logic        done, error, rd_pending;
    logic        busy, csr_wr_ok, start, clear, poll_expired;

    assign busy         = (state != IDLE) && (state != DONE) && (state != ERR);
    assign csr_wr_ok    = csr_write && !busy;
    assign start        = csr_wr_ok && (csr_address == 2'd3) && csr_writedata[0] && (state == IDLE);
    assign clear        = csr_wr_ok && (csr_address == 2'd3) && csr_writedata[8];
    assign poll_expired = (poll_cnt + 32'd1) >= 32'(TIMEOUT_CYCLES);

    always_comb begin
        next_state    = state;
        avm_address   = 32'd0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = 32'd0;
        acc_address   = 3'd0;
        acc_read      = 1'b0;
        acc_write     = 1'b0;
        acc_writedata = 32'd0;
        case (state)
            IDLE:     if (start) next_state = RD_A;
            RD_A: begin
                // Strobe drops once the read is accepted; the word arrives later on readdatavalid.
                avm_address = src_a;
                avm_read    = !rd_pending;
                if (rd_pending && avm_readdatavalid) next_state = WR_A;
            end
            WR_A: begin
                acc_write     = 1'b1;
                acc_address   = 3'd0;
                acc_writedata = word;
                next_state    = RD_B;
            end
            RD_B: begin
                avm_address = src_b;
                avm_read    = !rd_pending;
                if (rd_pending && avm_readdatavalid) next_state = WR_B;
            end
            WR_B: begin
                acc_write     = 1'b1;
                acc_address   = 3'd1;
                acc_writedata = word;
                next_state    = GO;
            end
            GO: begin
                acc_write     = 1'b1;
                acc_address   = 3'd2;
                acc_writedata = {24'd0, length, index, 1'b1, 1'b0};
                next_state    = POLL_RD;
            end
            POLL_RD: begin
                acc_read    = 1'b1;
                acc_address = 3'd2;
                next_state  = POLL_CHK;
            end
            POLL_CHK: begin
                if (acc_readdata[0])   next_state = RES_RD;
                else if (poll_expired) next_state = ERR;
                else                   next_state = POLL_RD;
            end
            RES_RD: begin
                acc_read    = 1'b1;
                acc_address = 3'd3;
                next_state  = RES_CAP;
            end
            RES_CAP:  next_state = WR_DST;
            WR_DST: begin
                avm_write     = 1'b1;
                avm_address   = dst;
                avm_writedata = result;
                if (!avm_waitrequest) next_state = DONE;
            end
            DONE:     next_state = IDLE;
            ERR:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    assign acc_chipselect = acc_read | acc_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            src_a        <= 32'd0;
            src_b        <= 32'd0;
            dst          <= 32'd0;
            result       <= 32'd0;
            word         <= 32'd0;
            index        <= 3'd0;
            length       <= 3'd0;
            poll_cnt     <= 32'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            rd_pending   <= 1'b0;
            csr_readdata <= 32'd0;
        end else begin
            state <= next_state;
            if (csr_wr_ok) begin
                case (csr_address)
                    2'd0:    src_a <= csr_writedata;
                    2'd1:    src_b <= csr_writedata;
                    2'd2:    dst   <= csr_writedata;
                    default: ;
                endcase
            end
            if (start) begin
                index    <= csr_writedata[4:2];
                length   <= csr_writedata[7:5];
                poll_cnt <= 32'd0;
                done     <= 1'b0;
                error    <= 1'b0;
            end else begin
                if (clear) begin
                    done  <= 1'b0;
                    error <= 1'b0;
                end
                if (state == POLL_CHK) poll_cnt <= poll_cnt + 32'd1;
                if (next_state == DONE) done  <= 1'b1;
                if (next_state == ERR)  error <= 1'b1;
            end
            if ((state == RD_A) || (state == RD_B)) begin
                if (!rd_pending && !avm_waitrequest) begin
                    rd_pending <= 1'b1;
                end else if (rd_pending && avm_readdatavalid) begin
                    rd_pending <= 1'b0;
                    word       <= avm_readdata;
                end
            end
            if (state == RES_CAP) result <= acc_readdata;
            if (csr_read) begin
                case (csr_address)
                    2'd0:    csr_readdata <= src_a;
                    2'd1:    csr_readdata <= src_b;
                    2'd2:    csr_readdata <= dst;
                    default: csr_readdata <= {29'd0, error, done, busy};
                endcase
            end
        end
    end

`ifdef STRING_HW_FEEDER_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                        irq_q <= 1'b0;
        else if ((next_state == DONE) || (next_state == ERR)) irq_q <= 1'b1;
        else if (clear)                                   irq_q <= 1'b0;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_string_hw_feeder.sv
// tb/tb_string_hw_feeder.sv - randomized self-checking bench with memory and accelerator models
module tb_string_hw_feeder;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  csr_address;
    logic        csr_write, csr_read;
    logic [31:0] csr_writedata, csr_readdata;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic [2:0]  acc_address;
    logic        acc_chipselect, acc_read, acc_write;
    logic [31:0] acc_writedata, acc_readdata;
    logic        irq;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    string_hw_feeder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .acc_address(acc_address), .acc_chipselect(acc_chipselect), .acc_read(acc_read),
        .acc_write(acc_write), .acc_writedata(acc_writedata), .acc_readdata(acc_readdata),
        .irq(irq)
    );

    // Memory model: configurable waitrequest per access, read data one cycle after acceptance.
    logic [31:0] rom [logic [31:0]];
    int          mem_wait_cfg = 0;
    int          mem_wait_left, mem_reads = 0, mem_writes = 0, mem_unstable = 0, proto_err = 0;
    bit          mem_in_access, rdv_next;
    logic [31:0] rdv_word, first_addr, first_data, last_wr_addr, last_wr_data;
    logic        first_rd;

    initial begin
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
        mem_in_access = 0; rdv_next = 0; mem_wait_left = 0;
        last_wr_addr = 32'd0; last_wr_data = 32'd0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (rdv_next) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = rdv_word;
                rdv_next          = 0;
            end
            if (avm_read && avm_write) proto_err++;
            if (acc_read && acc_write) proto_err++;
            if (acc_chipselect !== (acc_read | acc_write)) proto_err++;
            if (reset) begin
                mem_in_access   = 0;
                avm_waitrequest = 1'b0;
            end else if (avm_read || avm_write) begin
                if (!mem_in_access) begin
                    mem_in_access = 1;
                    mem_wait_left = mem_wait_cfg;
                    first_addr = avm_address; first_rd = avm_read; first_data = avm_writedata;
                end else if (avm_address !== first_addr || avm_read !== first_rd ||
                             avm_writedata !== first_data) begin
                    mem_unstable++;
                end
                if (mem_wait_left > 0) begin
                    avm_waitrequest = 1'b1;
                    mem_wait_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    mem_in_access   = 0;
                    if (avm_read) begin
                        mem_reads++;
                        rdv_next = 1;
                        rdv_word = rom.exists(avm_address) ? rom[avm_address] : 32'hdeadbeef;
                    end else begin
                        mem_writes++;
                        last_wr_addr = avm_address;
                        last_wr_data = avm_writedata;
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                mem_in_access   = 0;
            end
        end
    end

    // Accelerator model: reports done on the acc_done_after-th status poll (0 = never).
    int          acc_done_after = 0;
    int          acc_polls = 0;
    logic [31:0] acc_result = 32'd0;
    logic [2:0]  accw_addr_q [$];
    logic [31:0] accw_data_q [$];

    initial begin
        logic [31:0] r;
        acc_readdata = 32'd0;
        forever begin
            @(negedge clk);
            if (acc_write) begin
                accw_addr_q.push_back(acc_address);
                accw_data_q.push_back(acc_writedata);
                if (acc_address == 3'd2 && acc_writedata[1]) acc_polls = 0;
            end
            if (acc_read) begin
                r = $urandom();
                if (acc_address == 3'd2) begin
                    acc_polls++;
                    acc_readdata = {r[31:1], (acc_done_after != 0 && acc_polls >= acc_done_after)};
                end else if (acc_address == 3'd3) begin
                    acc_readdata = acc_result;
                end else begin
                    acc_readdata = r;
                end
            end
        end
    end

    function automatic logic [136:0] all_outs();
        return {avm_address, avm_read, avm_write, avm_writedata, acc_address, acc_chipselect,
                acc_read, acc_write, acc_writedata, irq, csr_readdata};
    endfunction

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        csr_address = a; csr_read = 1'b1;
        @(negedge clk);
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            csr_rd(2'd3, st);
            if (!st[0]) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL job_timeout: busy still set, status %h required busy 0", st); end
    endtask

    task automatic setup_job(input logic [31:0] a, b, sa, sb, sd, res, input int da, wt);
        rom[sa] = a; rom[sb] = b;
        acc_done_after = da; acc_result = res; mem_wait_cfg = wt;
        csr_wr(2'd0, sa); csr_wr(2'd1, sb); csr_wr(2'd2, sd);
    endtask

    task automatic run_job(input logic [31:0] a, b, sa, sb, sd, res, input logic [2:0] idx, len,
                           input int da, wt, output logic [31:0] st, output int ab, output int wb);
        setup_job(a, b, sa, sb, sd, res, da, wt);
        ab = accw_data_q.size();
        wb = mem_writes;
        csr_wr(2'd3, {24'd0, len, idx, 1'b0, 1'b1});
        wait_idle(st);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        n_cmp++;
        if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", all_outs()); end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            csr_rd(2'(i), d);
            n_cmp++;
            if (d !== 32'd0) begin n_fail++; $display("FAIL reset_csr%0d: got %h required 0", i, d); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] st; int ab, wb;
        run_job(32'h41424344, 32'h45464748, 32'h100, 32'h104, 32'h200, 32'h11223344, 3'd1, 3'd2,
                5, 0, st, ab, wb);
        n_cmp++;
        if (st !== 32'h2) begin n_fail++; $display("FAIL basic_status: got %h required 2", st); end
        n_cmp++;
        if (acc_polls !== 5) begin n_fail++; $display("FAIL basic_polls: got %0d required 5", acc_polls); end
        n_cmp++;
        if (mem_writes - wb !== 1 || last_wr_addr !== 32'h200 || last_wr_data !== 32'h11223344) begin
            n_fail++; $display("FAIL basic_dst: got %0d writes %h@%h required 1 write 11223344@200",
                               mem_writes - wb, last_wr_data, last_wr_addr);
        end
        n_cmp++;
        if (accw_data_q.size() !== ab + 3) begin
            n_fail++; $display("FAIL basic_acc_count: got %0d required 3", accw_data_q.size() - ab);
        end else if ({accw_addr_q[ab], accw_addr_q[ab+1], accw_addr_q[ab+2]} !== {3'd0, 3'd1, 3'd2} ||
                     {accw_data_q[ab], accw_data_q[ab+1], accw_data_q[ab+2]} !==
                     {32'h41424344, 32'h45464748, 32'h00000046}) begin
            n_fail++; $display("FAIL basic_acc_seq: got %h %h %h required 41424344 45464748 00000046",
                               accw_data_q[ab], accw_data_q[ab+1], accw_data_q[ab+2]);
        end
    endtask

    task automatic test_waitrequest();
        logic [31:0] st; int ab, wb, ub;
        ub = mem_unstable;
        run_job(32'h41424344, 32'h45464748, 32'h110, 32'h114, 32'h210, 32'h11223344, 3'd1, 3'd2,
                5, 3, st, ab, wb);
        n_cmp++;
        if (mem_unstable !== ub) begin n_fail++; $display("FAIL wait_stable: got %0d changes required 0", mem_unstable - ub); end
        n_cmp++;
        if (st !== 32'h2 || mem_writes - wb !== 1 || last_wr_data !== 32'h11223344 || last_wr_addr !== 32'h210) begin
            n_fail++; $display("FAIL wait_dst: got status %h data %h@%h required 2 11223344@210",
                               st, last_wr_data, last_wr_addr);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] st; int ab, wb;
        run_job(32'h01020304, 32'h05060708, 32'h120, 32'h124, 32'h220, 32'hcafef00d, 3'd3, 3'd4,
                0, 1, st, ab, wb);
        n_cmp++;
        if (st !== 32'h4) begin n_fail++; $display("FAIL timeout_status: got %h required 4", st); end
        n_cmp++;
        if (acc_polls !== TO) begin n_fail++; $display("FAIL timeout_polls: got %0d required %0d", acc_polls, TO); end
        n_cmp++;
        if (mem_writes !== wb) begin n_fail++; $display("FAIL timeout_nowrite: got %0d writes required 0", mem_writes - wb); end
    endtask

    task automatic test_reset_poll();
        logic [31:0] st, d; int ab, wb; bit seen = 0;
        setup_job(32'h0a0b0c0d, 32'h0e0f1011, 32'h130, 32'h134, 32'h230, 32'h1, 0, 0);
        csr_wr(2'd3, 32'h1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (acc_read && acc_address == 3'd2) begin seen = 1; break; end
        end
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL rstpoll_reach: got no poll read required one"); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (all_outs() !== '0) begin n_fail++; $display("FAIL rstpoll_outputs: got %h required 0", all_outs()); end
        @(negedge clk); reset = 1'b0;
        csr_rd(2'd0, d);
        n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL rstpoll_src_a: got %h required 0", d); end
        run_job(32'h21222324, 32'h25262728, 32'h140, 32'h144, 32'h240, 32'h5a5a1234, 3'd7, 3'd7,
                3, 0, st, ab, wb);
        n_cmp++;
        if (st !== 32'h2 || last_wr_data !== 32'h5a5a1234 || last_wr_addr !== 32'h240) begin
            n_fail++; $display("FAIL rstpoll_rerun: got status %h data %h@%h required 2 5a5a1234@240",
                               st, last_wr_data, last_wr_addr);
        end
    endtask

    task automatic test_reset_discard();
        logic [31:0] st; int ab, wb, rb; bit seen = 0;
        rb = mem_reads;
        setup_job(32'hbad0bad0, 32'hbad1bad1, 32'h150, 32'h154, 32'h250, 32'h2, 1, 0);
        csr_wr(2'd3, 32'h1);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (mem_reads != rb) begin seen = 1; break; end
        end
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL discard_reach: got no read accepted required one"); end
        run_job(32'h31323334, 32'h35363738, 32'h160, 32'h164, 32'h260, 32'h77665544, 3'd2, 3'd5,
                2, 1, st, ab, wb);
        n_cmp++;
        if (accw_data_q.size() !== ab + 3 || accw_data_q[ab] !== 32'h31323334 || st !== 32'h2 ||
            last_wr_data !== 32'h77665544) begin
            n_fail++; $display("FAIL discard_rerun: got A %h status %h dst %h required 31323334 2 77665544",
                               accw_data_q[ab], st, last_wr_data);
        end
    endtask

    task automatic test_busy_write();
        logic [31:0] st, d; int ab, wb;
        setup_job(32'h41424344, 32'h45464748, 32'h170, 32'h174, 32'h270, 32'h13579bdf, 7, 2);
        ab = accw_data_q.size();
        csr_wr(2'd3, 32'h1);
        csr_wr(2'd0, 32'h100);
        wait_idle(st);
        csr_rd(2'd0, d);
        n_cmp++;
        if (d !== 32'h170) begin n_fail++; $display("FAIL busy_src_a: got %h required 170", d); end
`ifdef STRING_HW_FEEDER_IRQ_EN
        n_cmp++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b required 1", irq); end
        csr_wr(2'd3, 32'h100);
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b required 0", irq); end
`else
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tied: got %b required 0", irq); end
        csr_wr(2'd3, 32'h100);
`endif
        csr_rd(2'd3, st);
        n_cmp++;
        if (st !== 32'h0) begin n_fail++; $display("FAIL busy_clear_status: got %h required 0", st); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] st; int wb, rb, ab; bit seen = 0;
        setup_job(32'h61626364, 32'h65666768, 32'h180, 32'h184, 32'h280, 32'h24681357, 2, 1);
        wb = mem_writes;
        csr_wr(2'd3, 32'h1);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (mem_writes != wb) begin seen = 1; break; end
        end
        // Now in DONE: a start issued this cycle must not launch a job.
        @(negedge clk);
        csr_address = 2'd3; csr_writedata = 32'h1; csr_write = 1'b1;
        @(negedge clk);
        csr_write = 1'b0;
        rb = mem_reads;
        repeat (6) @(negedge clk);
        csr_rd(2'd3, st);
        n_cmp++;
        if (!seen || st !== 32'h2 || mem_reads !== rb) begin
            n_fail++; $display("FAIL b2b_done_start: got status %h new reads %0d required 2 and 0",
                               st, mem_reads - rb);
        end
        run_job(32'h71727374, 32'h75767778, 32'h190, 32'h194, 32'h290, 32'h0f0e0d0c, 3'd5, 3'd1,
                1, 0, st, ab, wb);
        n_cmp++;
        if (st !== 32'h2 || last_wr_data !== 32'h0f0e0d0c || last_wr_addr !== 32'h290) begin
            n_fail++; $display("FAIL b2b_second: got status %h data %h@%h required 2 0f0e0d0c@290",
                               st, last_wr_data, last_wr_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] st, a, b, res, base, exp_go; logic [2:0] idx, len; int da, wt, ab, wb, exp_polls; bit ok;
        for (int it = 0; it < 10; it++) begin
            a = $urandom(); b = $urandom(); res = $urandom();
            idx = 3'($urandom_range(0, 7)); len = 3'($urandom_range(0, 7));
            da = $urandom_range(0, 9); wt = $urandom_range(0, 3);
            base = 32'h10000000 | (32'($urandom_range(0, 4095)) << 4);
            ok = (da != 0) && (da <= TO);
            exp_polls = ok ? da : TO;
            exp_go = {24'd0, len, idx, 2'b10};
            run_job(a, b, base, base + 32'd4, base + 32'd8, res, idx, len, da, wt, st, ab, wb);
            n_cmp++;
            if (st !== (ok ? 32'h2 : 32'h4) || acc_polls !== exp_polls) begin
                n_fail++; $display("FAIL rand%0d_status: got %h polls %0d required %h polls %0d",
                                   it, st, acc_polls, ok ? 32'h2 : 32'h4, exp_polls);
            end
            n_cmp++;
            if (mem_writes - wb !== (ok ? 1 : 0) || (ok && (last_wr_data !== res || last_wr_addr !== base + 32'd8))) begin
                n_fail++; $display("FAIL rand%0d_dst: got %0d writes %h@%h required %0d %h@%h",
                                   it, mem_writes - wb, last_wr_data, last_wr_addr, ok, res, base + 32'd8);
            end
            n_cmp++;
            if (accw_data_q.size() !== ab + 3 ||
                {accw_data_q[ab], accw_data_q[ab+1], accw_data_q[ab+2]} !== {a, b, exp_go}) begin
                n_fail++; $display("FAIL rand%0d_acc: got %h %h %h required %h %h %h", it,
                                   accw_data_q[ab], accw_data_q[ab+1], accw_data_q[ab+2], a, b, exp_go);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        csr_address = 2'd0; csr_write = 1'b0; csr_read = 1'b0; csr_writedata = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_waitrequest();
        test_timeout();
        test_reset_poll();
        test_reset_discard();
        test_busy_write();
        test_back_to_back();
        test_random();
        n_cmp++;
        if (proto_err !== 0) begin n_fail++; $display("FAIL protocol: got %0d violations required 0", proto_err); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
